// File: rtl/mips_pipeline.sv
// mips_pipeline: five-stage in-order MIPS32 integer core (IF, ID, EX, MEM, WB)
// with on-chip instruction and data memories.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - synchronous, active-low reset
//   result - write-back data of the most recent register write in WB
//   halt   - sticky, set once a HALT instruction has reached WB
//
// Branches and jumps resolve in ID (no delay slot, one squashed slot).
// imem is loaded hierarchically by the environment; regs is the 32x32
// architectural register file.
module mips_pipeline #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] result,
  output logic        halt
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
                         ALU_OR  = 3'd3, ALU_SLT = 3'd4;

  logic [31:0] imem [0:IMEM_WORDS-1] = '{default: '0};
  logic [31:0] dmem [0:DMEM_WORDS-1];
  logic [31:0] regs [0:31];

  // IF and IF/ID
  logic [31:0] pc, pc4;
  logic        halt_seen;
  logic [31:0] if_id_instr, if_id_pc4;

  // ID/EX
  logic        id_ex_we, id_ex_mr, id_ex_mw, id_ex_halt, id_ex_link, id_ex_imm_sel;
  logic [2:0]  id_ex_alu;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_dest;
  logic [31:0] id_ex_a, id_ex_b, id_ex_imm, id_ex_pc4;

  // EX/MEM
  logic        ex_mem_we, ex_mem_mr, ex_mem_mw, ex_mem_halt;
  logic [4:0]  ex_mem_dest;
  logic [31:0] ex_mem_res, ex_mem_sd;

  // MEM/WB
  logic        mem_wb_we, mem_wb_halt;
  logic [4:0]  mem_wb_dest;
  logic [31:0] mem_wb_data;

  // ---------------- ID decode ----------------
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] sext;

  assign op    = if_id_instr[31:26];
  assign rs    = if_id_instr[25:21];
  assign rt    = if_id_instr[20:16];
  assign rd    = if_id_instr[15:11];
  assign shamt = if_id_instr[10:6];
  assign funct = if_id_instr[5:0];
  assign sext  = {{16{if_id_instr[15]}}, if_id_instr[15:0]};

  logic       d_we, d_mr, d_mw, d_halt, d_link, d_imm;
  logic       use_rs, use_rt, br_rs, br_rt, d_beq, d_bne, d_jimm, d_jreg;
  logic [2:0] d_alu;
  logic [4:0] d_dest;

  always_comb begin
    d_we = 1'b0; d_mr = 1'b0; d_mw = 1'b0; d_halt = 1'b0; d_link = 1'b0;
    d_imm = 1'b0; d_alu = ALU_ADD; d_dest = rd;
    use_rs = 1'b0; use_rt = 1'b0; br_rs = 1'b0; br_rt = 1'b0;
    d_beq = 1'b0; d_bne = 1'b0; d_jimm = 1'b0; d_jreg = 1'b0;
    case (op)
      6'h00: if (shamt == 5'd0) begin
        case (funct)
          6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: begin
            d_we = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
            case (funct)
              6'h22:   d_alu = ALU_SUB;
              6'h24:   d_alu = ALU_AND;
              6'h25:   d_alu = ALU_OR;
              6'h2A:   d_alu = ALU_SLT;
              default: d_alu = ALU_ADD;
            endcase
          end
          6'h08: begin d_jreg = 1'b1; use_rs = 1'b1; br_rs = 1'b1; end
          6'h09: begin
            d_jreg = 1'b1; use_rs = 1'b1; br_rs = 1'b1; d_we = 1'b1; d_link = 1'b1;
            d_dest = (rd == 5'd0) ? 5'd31 : rd;
          end
          default: ;
        endcase
      end
      6'h08: begin d_we = 1'b1; use_rs = 1'b1; d_imm = 1'b1; d_dest = rt; end
      6'h23: begin d_we = 1'b1; d_mr = 1'b1; use_rs = 1'b1; d_imm = 1'b1; d_dest = rt; end
      6'h2B: begin d_mw = 1'b1; use_rs = 1'b1; use_rt = 1'b1; d_imm = 1'b1; end
      6'h04: begin d_beq = 1'b1; use_rs = 1'b1; use_rt = 1'b1; br_rs = 1'b1; br_rt = 1'b1; end
      6'h05: begin d_bne = 1'b1; use_rs = 1'b1; use_rt = 1'b1; br_rs = 1'b1; br_rt = 1'b1; end
      6'h02: d_jimm = 1'b1;
      6'h03: begin d_jimm = 1'b1; d_we = 1'b1; d_link = 1'b1; d_dest = 5'd31; end
      6'h3F: d_halt = 1'b1;
      default: ;
    endcase
  end

  // Register read: WB write is visible in the same cycle, and an ALU result
  // sitting in EX/MEM overrides it. A load in EX/MEM has no data yet.
  logic [31:0] rs_val, rt_val;
  always_comb begin
    rs_val = regs[rs];
    rt_val = regs[rt];
    if (mem_wb_we && mem_wb_dest == rs) rs_val = mem_wb_data;
    if (mem_wb_we && mem_wb_dest == rt) rt_val = mem_wb_data;
    if (ex_mem_we && !ex_mem_mr && ex_mem_dest == rs) rs_val = ex_mem_res;
    if (ex_mem_we && !ex_mem_mr && ex_mem_dest == rt) rt_val = ex_mem_res;
    if (rs == 5'd0) rs_val = '0;
    if (rt == 5'd0) rt_val = '0;
  end

  // Hazards: ID-resolved control needs its operands one stage earlier than
  // the ALU does, so any producer in EX (and a load in MEM) blocks it.
  logic ex_rs, ex_rt, ld_rs, ld_rt, stall, taken;
  logic [31:0] target;
  assign ex_rs = id_ex_we && id_ex_dest != 5'd0 && id_ex_dest == rs;
  assign ex_rt = id_ex_we && id_ex_dest != 5'd0 && id_ex_dest == rt;
  assign ld_rs = ex_mem_mr && ex_mem_dest != 5'd0 && ex_mem_dest == rs;
  assign ld_rt = ex_mem_mr && ex_mem_dest != 5'd0 && ex_mem_dest == rt;
  assign stall = (br_rs && (ex_rs || ld_rs)) || (br_rt && (ex_rt || ld_rt)) ||
                 (id_ex_mr && ((use_rs && ex_rs) || (use_rt && ex_rt)));
  assign taken = !stall && ((d_beq && rs_val == rt_val) || (d_bne && rs_val != rt_val) ||
                            d_jimm || d_jreg);
  assign target = d_jreg ? rs_val :
                  d_jimm ? {if_id_pc4[31:28], if_id_instr[25:0], 2'b00} :
                           if_id_pc4 + {sext[29:0], 2'b00};
  assign pc4 = pc + 32'd4;

  // ---------------- EX ----------------
  logic [31:0] fa, fb, opb, alu_y, ex_res;
  always_comb begin
    fa = id_ex_a;
    fb = id_ex_b;
    if (mem_wb_we && mem_wb_dest != 5'd0 && mem_wb_dest == id_ex_rs) fa = mem_wb_data;
    if (mem_wb_we && mem_wb_dest != 5'd0 && mem_wb_dest == id_ex_rt) fb = mem_wb_data;
    if (ex_mem_we && !ex_mem_mr && ex_mem_dest != 5'd0 && ex_mem_dest == id_ex_rs) fa = ex_mem_res;
    if (ex_mem_we && !ex_mem_mr && ex_mem_dest != 5'd0 && ex_mem_dest == id_ex_rt) fb = ex_mem_res;
    opb = id_ex_imm_sel ? id_ex_imm : fb;
    case (id_ex_alu)
      ALU_SUB: alu_y = fa - opb;
      ALU_AND: alu_y = fa & opb;
      ALU_OR:  alu_y = fa | opb;
      ALU_SLT: alu_y = {31'b0, ($signed(fa) < $signed(opb))};
      default: alu_y = fa + opb;
    endcase
    // Links carry their return address down the ALU-result path so the
    // normal forwarding network serves them too.
    ex_res = id_ex_link ? id_ex_pc4 : alu_y;
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= '0; halt_seen <= 1'b0;
      if_id_instr <= '0; if_id_pc4 <= '0;
      id_ex_we <= 1'b0; id_ex_mr <= 1'b0; id_ex_mw <= 1'b0; id_ex_halt <= 1'b0;
      id_ex_link <= 1'b0; id_ex_imm_sel <= 1'b0; id_ex_alu <= ALU_ADD;
      id_ex_rs <= '0; id_ex_rt <= '0; id_ex_dest <= '0;
      id_ex_a <= '0; id_ex_b <= '0; id_ex_imm <= '0; id_ex_pc4 <= '0;
      ex_mem_we <= 1'b0; ex_mem_mr <= 1'b0; ex_mem_mw <= 1'b0; ex_mem_halt <= 1'b0;
      ex_mem_dest <= '0; ex_mem_res <= '0; ex_mem_sd <= '0;
      mem_wb_we <= 1'b0; mem_wb_halt <= 1'b0; mem_wb_dest <= '0; mem_wb_data <= '0;
      result <= '0; halt <= 1'b0;
    end else begin
      // Once HALT is decoded the front end stays frozen feeding NOPs.
      if (!stall) begin
        if (halt_seen || d_halt) begin
          if_id_instr <= '0;
        end else if (taken) begin
          pc          <= target;
          if_id_instr <= '0;
        end else begin
          pc          <= pc4;
          if_id_instr <= imem[pc[IAW+1:2]];
          if_id_pc4   <= pc4;
        end
      end
      if (d_halt && !stall) halt_seen <= 1'b1;

      // A stall turns the ID/EX entry into a bubble by dropping its controls.
      id_ex_we      <= d_we && !stall;
      id_ex_mr      <= d_mr && !stall;
      id_ex_mw      <= d_mw && !stall;
      id_ex_halt    <= d_halt && !stall;
      id_ex_link    <= d_link;
      id_ex_imm_sel <= d_imm;
      id_ex_alu     <= d_alu;
      id_ex_rs      <= rs;
      id_ex_rt      <= rt;
      id_ex_dest    <= d_dest;
      id_ex_a       <= rs_val;
      id_ex_b       <= rt_val;
      id_ex_imm     <= sext;
      id_ex_pc4     <= if_id_pc4;

      ex_mem_we   <= id_ex_we;
      ex_mem_mr   <= id_ex_mr;
      ex_mem_mw   <= id_ex_mw;
      ex_mem_halt <= id_ex_halt;
      ex_mem_dest <= id_ex_dest;
      ex_mem_res  <= ex_res;
      ex_mem_sd   <= fb;

      mem_wb_we   <= ex_mem_we;
      mem_wb_halt <= ex_mem_halt;
      mem_wb_dest <= ex_mem_dest;
      mem_wb_data <= ex_mem_mr ? dmem[ex_mem_res[DAW+1:2]] : ex_mem_res;

      if (mem_wb_halt) halt <= 1'b1;
      if (mem_wb_we && mem_wb_dest != 5'd0) result <= mem_wb_data;
    end
  end

  // Register file; $0 is never written.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (mem_wb_we && mem_wb_dest != 5'd0) begin
      regs[mem_wb_dest] <= mem_wb_data;
    end
  end

  // Data memory keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (reset && ex_mem_mw) dmem[ex_mem_res[DAW+1:2]] <= ex_mem_sd;
  end
endmodule

// File: tb/tb_mips_pipeline.sv
// Bench for mips_pipeline: directed programs with cycle-exact checks plus
// random forward-only programs, all compared against an instruction-level
// interpreter of the ISA.
module tb_mips_pipeline;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] result;
  logic        halt;

  mips_pipeline #(.IMEM_WORDS(256), .DMEM_WORDS(256)) dut (
    .clk(clk), .reset(reset), .result(result), .halt(halt)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] HALT_I = 32'hFC00_0000;

  int errs = 0, checks = 0;
  logic [31:0] prog   [0:255];
  logic [31:0] mreg   [0:31];
  logic [31:0] mmem   [0:255];
  logic [31:0] res_at [0:511];
  logic [31:0] mres;
  int          halt_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input int s, input int t, input int d);
    return {6'h00, 5'(s), 5'(t), 5'(d), 5'h00, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input int s, input int t, input int imm);
    return {op, 5'(s), 5'(t), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] addr);
    return {op, addr[27:2]};
  endfunction
  function automatic logic [31:0] addi(input int t, input int s, input int imm);
    return enc_i(6'h08, s, t, imm);
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'h0;
  endtask

  // ISA-level interpreter: one instruction per step, architectural state only.
  task automatic mwr(input logic [4:0] d, input logic [31:0] v);
    if (d != 5'd0) begin mreg[d] = v; mres = v; end
  endtask

  task automatic run_model();
    logic [31:0] pc, npc, ins, a, b, sx, ad;
    logic [4:0]  s, t, d;
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    for (int i = 0; i < 256; i++) mmem[i] = '0;
    mres = '0;
    pc = '0;
    for (int step = 0; step < 4000; step++) begin
      ins = prog[pc[9:2]];
      npc = pc + 4;
      s = ins[25:21]; t = ins[20:16]; d = ins[15:11];
      a = mreg[s]; b = mreg[t];
      sx = {{16{ins[15]}}, ins[15:0]};
      ad = a + sx;
      if (ins[31:26] == 6'h3F) break;
      case (ins[31:26])
        6'h00: case (ins[5:0])
          6'h20: mwr(d, a + b);
          6'h22: mwr(d, a - b);
          6'h24: mwr(d, a & b);
          6'h25: mwr(d, a | b);
          6'h2A: mwr(d, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
          6'h08: npc = a;
          6'h09: begin mwr((d == 5'd0) ? 5'd31 : d, pc + 4); npc = a; end
          default: ;
        endcase
        6'h08: mwr(t, ad);
        6'h23: mwr(t, mmem[ad[9:2]]);
        6'h2B: mmem[ad[9:2]] = b;
        6'h04: if (a == b) npc = pc + 4 + (sx << 2);
        6'h05: if (a != b) npc = pc + 4 + (sx << 2);
        6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
        6'h03: begin mwr(5'd31, pc + 4); npc = {npc[31:28], ins[25:0], 2'b00}; end
        default: ;
      endcase
      pc = npc;
    end
  endtask

  // One reset edge, reset-state checks, then run until halt or the budget.
  task automatic run_dut(input int limit);
    logic [31:0] any;
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    any = '0;
    for (int i = 0; i < 32; i++) any |= dut.regs[i];
    chk("rst_pc", dut.pc, 32'h0);
    chk("rst_halt", {31'b0, halt}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_regs", any, 32'h0);
    reset = 1'b1;
    halt_cyc = -1;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk);
      #1;
      res_at[c] = result;
      if (halt) begin halt_cyc = c; break; end
    end
  endtask

  task automatic compare_all(input string tag, input bit with_mem);
    for (int i = 1; i < 32; i++) chk($sformatf("%s r%0d", tag, i), dut.regs[i], mreg[i]);
    if (with_mem)
      for (int i = 0; i < 16; i++) chk($sformatf("%s m%0d", tag, i), dut.dmem[i], mmem[i]);
    chk({tag, " result"}, result, mres);
    chk({tag, " halt"}, {31'b0, halt}, 32'h1);
  endtask

  task automatic run_test(input string tag, input int limit, input bit with_mem);
    for (int i = 0; i < 256; i++) dut.imem[i] = prog[i];
    run_model();
    run_dut(limit);
    compare_all(tag, with_mem);
  endtask

  function automatic logic [31:0] rnd_ins(input int i, input int n);
    logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    int k  = int'($urandom_range(0, 9));
    int s  = int'($urandom_range(0, 7));
    int s2 = int'($urandom_range(0, 7));
    int t  = int'($urandom_range(1, 7));
    int w  = int'($urandom_range(0, 15)) * 4;
    case (k)
      0, 1, 2: return enc_r(fns[$urandom_range(0, 4)], s, s2, t);
      4: return enc_i(6'h23, 0, t, w);
      5: return enc_i(6'h2B, 0, s, w);
      6: return enc_i($urandom_range(0, 1) ? 6'h04 : 6'h05, s, s2, int'($urandom_range(0, n - 1 - i)));
      7: return enc_j($urandom_range(0, 1) ? 6'h02 : 6'h03, 32'($urandom_range(i + 1, n)) * 4);
      8: return enc_i(6'h0D, s, t, int'($urandom));
      default: return addi(t, s, int'($urandom_range(0, 65535)));
    endcase
  endfunction

  initial begin
    // Write-back latency and HALT: nothing after HALT is written.
    clear_prog();
    prog[0] = addi(1, 0, 9); prog[1] = HALT_I; prog[2] = addi(2, 0, 3);
    run_test("halt", 100, 1'b0);
    chk("wb_lat c4", res_at[4], 32'd0);
    chk("wb_lat c5", res_at[5], 32'd9);
    chk("halt cyc", 32'(halt_cyc), 32'd6);
    chk("halt r2", dut.regs[2], 32'd0);

    // JR through a register produced one instruction earlier.
    clear_prog();
    prog[0] = addi(1, 0, 5);  prog[1] = addi(2, 0, 100); prog[2] = addi(16, 0, 24);
    prog[3] = enc_r(6'h08, 16, 0, 0);
    prog[4] = addi(3, 0, 1);  prog[5] = addi(4, 0, 1);
    prog[6] = enc_r(6'h20, 1, 2, 5); prog[7] = addi(6, 0, 6); prog[8] = HALT_I;
    run_test("jr", 100, 1'b0);
    chk("jr r5", dut.regs[5], 32'd105);
    chk("jr r3", dut.regs[3], 32'd0);
    chk("jr cyc", 32'(halt_cyc), 32'd13);

    // JALR with rd=0 links into $31.
    clear_prog();
    prog[0] = addi(7, 0, 64); prog[1] = enc_r(6'h09, 7, 0, 0);
    prog[2] = addi(8, 0, 8);  prog[3] = addi(9, 0, 9); prog[4] = addi(10, 0, 10);
    prog[16] = addi(11, 0, 11); prog[17] = HALT_I;
    run_test("jalr", 100, 1'b0);
    chk("jalr r31", dut.regs[31], 32'd8);
    chk("jalr r9", dut.regs[9], 32'd0);

    // Load-use stall, then a taken BEQ on the loaded value.
    clear_prog();
    prog[0] = addi(1, 0, 7); prog[1] = enc_i(6'h2B, 0, 1, 0); prog[2] = enc_i(6'h23, 0, 2, 0);
    prog[3] = enc_r(6'h20, 2, 2, 3); prog[4] = enc_i(6'h04, 2, 1, 1);
    prog[5] = addi(4, 0, 1); prog[6] = HALT_I;
    run_test("ldu", 100, 1'b0);
    chk("ldu r3", dut.regs[3], 32'd14);
    chk("ldu cyc", 32'(halt_cyc), 32'd12);

    // Reset mid-program, then the same program reruns identically.
    run_dut(6);
    run_dut(100);
    compare_all("rerun", 1'b0);
    chk("rerun cyc", 32'(halt_cyc), 32'd12);

    // Load feeding a branch costs two stall cycles.
    clear_prog();
    prog[0] = addi(1, 0, 7); prog[1] = enc_i(6'h2B, 0, 1, 4); prog[2] = enc_i(6'h23, 0, 5, 4);
    prog[3] = enc_i(6'h04, 5, 1, 1); prog[4] = addi(6, 0, 1); prog[5] = HALT_I;
    run_test("ldbr", 100, 1'b0);
    chk("ldbr cyc", 32'(halt_cyc), 32'd12);

    // BNE not taken, J and JAL.
    clear_prog();
    prog[0] = enc_i(6'h05, 0, 0, 3); prog[1] = addi(1, 0, 1); prog[2] = enc_j(6'h02, 32'h40);
    prog[16] = addi(2, 0, 2); prog[17] = enc_j(6'h03, 32'h80); prog[18] = addi(3, 0, 3);
    prog[32] = HALT_I;
    run_test("jal", 100, 1'b0);
    chk("jal r31", dut.regs[31], 32'h48);
    chk("jal r1", dut.regs[1], 32'd1);

    // Jump squash timing: target fetched the cycle after ID.
    clear_prog();
    prog[0] = enc_j(6'h02, 32'h10); prog[1] = addi(8, 0, 1); prog[4] = HALT_I;
    run_test("jmp", 100, 1'b0);
    chk("jmp cyc", 32'(halt_cyc), 32'd7);

    // Random forward-only programs; a prologue zeroes the checked memory.
    for (int t = 0; t < 10; t++) begin
      clear_prog();
      for (int w = 0; w < 16; w++) prog[w] = enc_i(6'h2B, 0, 0, w * 4);
      for (int i = 16; i < 40; i++) prog[i] = rnd_ins(i, 40);
      prog[40] = HALT_I;
      run_test($sformatf("rnd%0d", t), 400, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mips_pipeline.md
# mips_pipeline

Five-stage in-order MIPS32 integer pipeline (IF, ID, EX, MEM, WB) with on-chip instruction and data memories. It is the top-level processor block; only `result` and `halt` leave the block. Branches and jumps resolve in ID, with ID-stage forwarding. The register file is hierarchically visible to benches as a 32×32 array.

## Interface
- IMEM_WORDS, 256, instruction memory depth in 32-bit words (word index = PC[9:2]); bench-loadable array, zero-initialised.
- DMEM_WORDS, 256, data memory depth in words (index = addr[9:2]).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-low.
- result  out  32  write-back data of the most recent instruction that wrote a register in WB.
- halt  out  1  sticky; high once a HALT instruction reaches WB.

## Operation
- Supported instructions: ADD, SUB, AND, OR, SLT, JR, JALR (R-type, opcode 0); ADDI, LW, SW, BEQ, BNE, J, JAL; HALT = opcode 6'b111111. Any other opcode is executed as a NOP.
- Encoding 32'h0 is NOP and writes nothing. Writes to $0 are discarded; $0 always reads 0.
- ADDI and LW/SW offsets are sign-extended. Arithmetic wraps mod 2^32 with no overflow traps. SLT is a signed compare.
- No branch delay slot. When a branch or jump is taken in ID:
  - the instruction currently in IF is squashed (IF/ID becomes NOP);
  - PC loads the target on the same edge.
- Branch target = PC+4 + (signext(imm)<<2). J/JAL target = {PC+4[31:28], imm26, 2'b00}. JR/JALR target = rs value.
- JAL writes PC+4 into $31. JALR writes PC+4 into rd (rd=0 encodes as 31).
- ID forwarding for branch compare and JR/JALR source: EX/MEM ALU result first, then MEM/WB write data, then the register file.
- EX forwarding for ALU operands: EX/MEM first, then MEM/WB.
- Register file is write-before-read: a WB write in the same cycle as an ID read returns the new value.
- Stall rules (PC and IF/ID hold; a NOP bubble is inserted into ID/EX):
  - one cycle when ID needs rs/rt produced by an ALU instruction in EX (branch, JR or JALR);
  - load-use: one cycle when an EX load feeds any ID consumer;
  - two cycles when a load feeds a branch or JR/JALR.
- HALT handling:
  - decoded in ID: PC freezes and IF/ID holds a NOP;
  - older instructions drain;
  - `halt` asserts when HALT reaches WB and stays high until reset.

## Timing
- Reset (reset=0 at a clock edge):
  - PC=0; all pipeline registers hold NOP;
  - all 32 registers, result and halt = 0;
  - data memory is not cleared.
- First fetch of address 0 occurs in the first cycle after reset deasserts.
- An ALU instruction fetched in cycle n writes the register file at the end of cycle n+4. `result` updates on that same edge.
- Taken branch or jump: exactly one squashed slot; target fetched in the cycle after ID.
- PC wraps modulo IMEM size (PC[31:10] ignored for fetch).
- Reset mid-operation overrides stall, flush and halt on the same edge.
- SW and LW complete in MEM on a single edge; no wait states.

## Test plan
- ADDI $1,$0,5; ADDI $2,$0,100; ADDI $16,$0,24; JR $16; ADDI $3,$0,1 (addr 16); ADDI $4,$0,1 (addr 20); ADD $5,$1,$2 (addr 24); ADDI $6,$0,6 -> $1=5, $2=100, $16=24, $3=0, $4=0, $5=105, $6=6.
- ADDI $7,$0,64; JALR $7; three ADDI writing $8/$9/$10 skipped; at 64 ADDI $11,$0,11 -> $7=64, $8=$9=$10=0, $11=11, $31 = JALR address+4.
- ADDI $1,$0,7; SW $1,0($0); LW $2,0($0); ADD $3,$2,$2 -> $3=14, one stall cycle; then BEQ $2,$1 taken with the following instruction squashed.
- BNE $0,$0 not taken, then J to 0x40 and JAL to 0x80 -> fall-through executes; $31 = JAL address+4.
- HALT after ADDI $1,$0,9 -> halt rises with the ADDI's result=9 already visible; the instruction after HALT is never written.
- Assert reset for one edge mid-program -> PC=0, halt=0, result=0, registers 0; program reruns identically.
